// File: rtl/tx_framer_if.sv
// Byte-source / dibit-mapper handshake bundle for tx_framer.
interface tx_framer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic       out_I;
  logic       out_Q;
  logic       out_ready;

  // Byte source and mapper side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_I, out_Q
  );

  // Framer side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_I, out_Q
  );
endinterface

// File: rtl/tx_framer.sv
// Byte-to-dibit framer: preamble, sync word, payload and, when TX_FRAMER_CRC16_EN
// is defined, a CRC-16/CCITT-FALSE trailer; every byte sent MSB-first as {I,Q}.
module tx_framer #(
  parameter int unsigned PREAMBLE_LEN = 4,
  parameter logic [15:0] SYNC_WORD    = 16'h2DD4,
  parameter int unsigned MAX_PAYLOAD  = 255
) (
  input  logic       clk,
  input  logic       rst,
  tx_framer_if.slave bus,
  output logic       frame_active,
  output logic       err_overlength
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SEC_W = 4;
  localparam int unsigned DIB_W = 2;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_PAYLOAD,
`ifdef TX_FRAMER_CRC16_EN
    S_CRC,
`endif
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         sh_q, sh_d;
  logic [DIB_W-1:0]   d_q, d_d;
  logic               valid_q, valid_d;
  logic               fa_q, fa_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [CNT_W-1:0]   pay_q, pay_d;
  logic               last_q, last_d;
  logic               ovf_q, ovf_d;
  logic               hs, byte_done;
  logic               take, in_ready_c, err_c;
`ifdef TX_FRAMER_CRC16_EN
  logic [15:0]        crc_q, crc_d;

  // One whole payload byte folded into the CRC per call.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction
`endif

  assign hs        = valid_q & bus.out_ready;
  assign byte_done = hs & (d_q == DIB_W'(3));

  // Next-state, shift register and frame bookkeeping.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    d_d        = d_q;
    valid_d    = valid_q;
    fa_d       = fa_q;
    sec_d      = sec_q;
    pay_d      = pay_q;
    last_d     = last_q;
    ovf_d      = ovf_q;
`ifdef TX_FRAMER_CRC16_EN
    crc_d      = crc_q;
`endif
    take       = 1'b0;
    in_ready_c = 1'b0;
    err_c      = 1'b0;

    if (hs) begin
      sh_d = {sh_q[5:0], 2'b00};
      d_d  = d_q + DIB_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        fa_d    = 1'b0;
        if (bus.in_valid) begin
          sh_d    = PREAMBLE_BYTE;
          d_d     = DIB_W'(0);
          valid_d = 1'b1;
          fa_d    = 1'b1;
          sec_d   = SEC_W'(0);
          pay_d   = CNT_W'(0);
          last_d  = 1'b0;
          ovf_d   = 1'b0;
`ifdef TX_FRAMER_CRC16_EN
          crc_d   = 16'hFFFF;
`endif
          state_d = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (byte_done) begin
          if (sec_q == SEC_W'(PREAMBLE_LEN - 1)) begin
            sh_d    = SYNC_WORD[15:8];
            sec_d   = SEC_W'(0);
            state_d = S_SYNC;
          end else begin
            sh_d  = PREAMBLE_BYTE;
            sec_d = sec_q + SEC_W'(1);
          end
        end
      end
      S_SYNC: begin
        if (byte_done) begin
          if (sec_q == SEC_W'(0)) begin
            sh_d  = SYNC_WORD[7:0];
            sec_d = SEC_W'(1);
          end else begin
            // Hand over with an empty register, but let the first payload byte in on this edge.
            valid_d    = 1'b0;
            state_d    = S_PAYLOAD;
            in_ready_c = 1'b1;
            take       = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (!valid_q) begin
          in_ready_c = 1'b1;
          take       = 1'b1;
        end else if (byte_done) begin
          valid_d = 1'b0;
          if (last_q) begin
`ifdef TX_FRAMER_CRC16_EN
            valid_d = 1'b1;
            sh_d    = crc_q[15:8];
            sec_d   = SEC_W'(0);
            state_d = S_CRC;
`else
            fa_d    = 1'b0;
            state_d = ovf_q ? S_DRAIN : S_IDLE;
`endif
          end else begin
            in_ready_c = 1'b1;
            take       = 1'b1;
          end
        end
      end
`ifdef TX_FRAMER_CRC16_EN
      S_CRC: begin
        if (byte_done) begin
          if (sec_q == SEC_W'(0)) begin
            sh_d  = crc_q[7:0];
            sec_d = SEC_W'(1);
          end else begin
            valid_d = 1'b0;
            fa_d    = 1'b0;
            state_d = ovf_q ? S_DRAIN : S_IDLE;
          end
        end
      end
`endif
      S_DRAIN: begin
        valid_d    = 1'b0;
        fa_d       = 1'b0;
        in_ready_c = 1'b1;
        if (bus.in_valid && bus.in_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Payload byte accept; truncation marks the byte as final and flags the error.
    if (take && bus.in_valid) begin
      sh_d    = bus.in_data;
      d_d     = DIB_W'(0);
      valid_d = 1'b1;
      pay_d   = pay_q + CNT_W'(1);
`ifdef TX_FRAMER_CRC16_EN
      crc_d   = crc_step(crc_q, bus.in_data);
`endif
      if (bus.in_last) begin
        last_d = 1'b1;
      end else if (pay_d == CNT_W'(MAX_PAYLOAD)) begin
        last_d = 1'b1;
        ovf_d  = 1'b1;
        err_c  = 1'b1;
      end else begin
        last_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      sh_q    <= 8'h00;
      d_q     <= DIB_W'(0);
      valid_q <= 1'b0;
      fa_q    <= 1'b0;
      sec_q   <= SEC_W'(0);
      pay_q   <= CNT_W'(0);
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef TX_FRAMER_CRC16_EN
      crc_q   <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      fa_q    <= fa_d;
      sec_q   <= sec_d;
      pay_q   <= pay_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
`ifdef TX_FRAMER_CRC16_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_I      = sh_q[7];
  assign bus.out_Q      = sh_q[6];
  assign bus.in_ready   = in_ready_c;
  assign frame_active   = fa_q;
  assign err_overlength = err_c;
endmodule

// File: doc/tx_framer.md
Name: tx_framer

Overview:
- Byte-to-dibit framing stage directly upstream of TX_path_top.
- Takes a byte stream with end-of-packet marker from the byte source. Prepends a preamble and sync word, and optionally appends a CRC-16.
- Serializes every byte MSB-first into dibits {in_I,in_Q} = {byte[7],byte[6]}, {byte[5],byte[4]}, and so on.
- Replaces the ad-hoc shift/counter feeding the QPSK mapper.

Parameters:
- PREAMBLE_LEN, 4, number of 0x55 preamble bytes per frame (1..15).
- SYNC_WORD, 16'h2DD4, sync word; high byte sent first.
- MAX_PAYLOAD, 255, maximum payload bytes per frame (1..255); byte counter is 8 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_last  in  1  last byte of packet, qualified by in_valid
- in_ready  out  1  input byte accepted when in_valid & in_ready
- out_valid  out  1  dibit valid
- out_I  out  1  I bit to mapper
- out_Q  out  1  Q bit to mapper
- out_ready  in  1  mapper ready
- frame_active  out  1  high from first preamble dibit until last frame dibit is accepted
- err_overlength  out  1  one-cycle pulse on truncation

Behaviour:
- Reset (rst=0, async) clears all of the following to 0: out_valid, out_I, out_Q, in_ready, frame_active, err_overlength, counters and CRC. State goes to IDLE. Reset mid-frame abandons the frame; no partial dibits are emitted after release.
- Internal byte register sh[7:0] with dibit index d (0..3). out_I=sh[7], out_Q=sh[6]. A dibit handshake (out_valid&out_ready) shifts sh left by 2 and increments d.
- While out_valid=1 and out_ready=0, out_I/out_Q/out_valid are held stable.
- States:
  - IDLE: out_valid=0, in_ready=0. When in_valid=1 (byte not consumed), load 0x55 and go to PREAMBLE. out_valid and frame_active rise the next cycle.
  - PREAMBLE: emit PREAMBLE_LEN bytes of 0x55. On the 4th dibit handshake of the last byte, load SYNC_WORD[15:8] and go to SYNC.
  - SYNC: emit 2 bytes, then go to PAYLOAD with the register empty.
  - PAYLOAD:
    - in_ready=1 when the register is empty, or when d=3 with out_ready=1 (zero-bubble reload).
    - An accepted byte is loaded into sh, feeds the CRC, and increments the byte count.
    - Register empty and in_valid=0: out_valid=0 (underrun bubble); the frame continues.
    - Accepted byte with in_last=1: after its 4th dibit, go to CRC (if enabled) else IDLE.
  - Overlength: byte count reaches MAX_PAYLOAD with in_last=0.
    - err_overlength pulses in the accept cycle.
    - Frame ends after that byte (CRC of the truncated payload if enabled).
    - Then go to DRAIN.
  - DRAIN: out_valid=0, frame_active=0, in_ready=1. Discard bytes up to and including in_last=1, then go to IDLE.
  - CRC: emit crc[15:8] then crc[7:0], then go to IDLE.
- Return to IDLE happens on the final dibit handshake, which clears frame_active. Between back-to-back frames out_valid is low for exactly 1 cycle.
- in_ready is 0 in IDLE, PREAMBLE, SYNC and CRC.
- Byte count and CRC reset at frame start.

Optional Feature:
- Macro: TX_FRAMER_CRC16_EN.
- Defined:
  - CRC-16/CCITT-FALSE over payload bytes: poly 0x1021, init 0xFFFF, no reflection, no xorout.
  - Computed byte-wise in one cycle per accepted byte.
  - Transmitted as 2 bytes, high byte first, in state CRC.
- Undefined: no CRC state or logic; the frame ends after the last payload dibit.

Test Plan:
- Single byte 0xA5, last=1, PREAMBLE_LEN=4, SYNC 0x2DD4, CRC off, out_ready=1 -> expected dibit sequence:
  - 16 dibits (0,1)
  - then 00 10 11 01 11 01 01 00
  - then 10 10 01 01
  - frame_active high for exactly 28 cycles; out_valid low 1 cycle after the frame.
- CRC on, payload "123456789" (0x31..0x39) -> last 8 dibits encode 0x29B1 = 00 10 10 01 10 11 00 01.
- Random out_ready backpressure (~50%) on a 10-byte payload -> dibit sequence identical to the out_ready=1 run; out_I/out_Q never change while out_valid&!out_ready.
- Source underrun: in_valid drops for 5 cycles mid-payload -> out_valid low for those cycles (plus 0 extra); no dibit lost or duplicated.
- MAX_PAYLOAD=4, 7-byte packet -> 4 payload bytes emitted, err_overlength 1-cycle pulse on the 4th accept, bytes 5–7 consumed with no output, next packet framed normally.
- rst asserted mid-SYNC, released, new 2-byte packet -> outputs 0 during reset; full new preamble emitted; no residue of the aborted frame.
